// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : Host-to-device PS/2 transmitter. Sends one command byte such as
//            0xED (set LEDs), 0xFF (reset) or 0xF3 (typematic rate) to the
//            keyboard. The open-drain ps2_clk/ps2_data lines are driven only
//            through output enables (oe=1 pulls low, oe=0 releases).
// Ports    : clk, rst_n       - system clock, synchronous active-low reset
//            tx_data/tx_valid - command byte and request (taken when ready)
//            tx_ready         - high only while idle
//            tx_done/tx_err   - one-cycle completion / failure pulses
//            ps2_clk_i/ps2_data_i   - raw asynchronous pin levels
//            ps2_clk_oe/ps2_data_oe - 1 = pull the line low
//            rx_inhibit       - high whenever a transfer is in progress
// Options  : define PS2_TX_RETRY_EN to retry a failed byte exactly once
//            before reporting tx_err.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit
);

  // One counter serves both the inhibit interval and the ACK timeout; the
  // two phases never overlap.
  localparam int c_CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int c_CW = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CW-1:0] c_INH_LAST = c_CW'(INHIBIT_CYCLES - 1);
  localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_START     = 3'd2,
    S_RELEASE   = 3'd3,
    S_BITS      = 3'd4,
    S_ACK       = 3'd5,
    S_WAIT_IDLE = 3'd6
  } state_t;

  state_t            r_state;
  logic [8:0]        r_shift;     // {parity, data[7:0]}
  logic [3:0]        r_bit;       // falling-edge index k within the bit phase
  logic [c_CW-1:0]   r_cnt;
  logic              r_clk_s1, r_clk_s2, r_clk_prev;
  logic              r_data_s1, r_data_s2;
  logic              r_tx_ready, r_tx_done, r_tx_err;
  logic              r_clk_oe, r_data_oe, r_rx_inhibit;

  logic              w_clk_fall;
  logic              w_timed;
  logic              w_timeout;
  logic              w_nack;
  logic              w_fail;
  logic              w_retry;

  assign w_clk_fall = r_clk_prev & ~r_clk_s2;
  assign w_timed    = (r_state == S_RELEASE) || (r_state == S_BITS) ||
                      (r_state == S_ACK)     || (r_state == S_WAIT_IDLE);
  assign w_timeout  = w_timed && (r_cnt == c_TMO_LAST);
  assign w_nack     = (r_state == S_ACK) && w_clk_fall && r_data_s2;
  assign w_fail     = w_timeout | w_nack;

`ifdef PS2_TX_RETRY_EN
  // Set by the first failure of a byte; any return to idle clears it.
  logic r_retry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retry <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_retry <= 1'b0;
    end else if (w_fail) begin
      r_retry <= 1'b1;
    end
  end

  assign w_retry = w_fail & ~r_retry;
`else
  assign w_retry = 1'b0;
`endif

  // Synchronizers reset to the released (high) bus level so that leaving
  // reset never manufactures a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_i;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= ps2_data_i;
      r_data_s2  <= r_data_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit        <= '0;
      r_cnt        <= '0;
      r_tx_ready   <= 1'b1;
      r_tx_done    <= 1'b0;
      r_tx_err     <= 1'b0;
      r_clk_oe     <= 1'b0;
      r_data_oe    <= 1'b0;
      r_rx_inhibit <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_shift      <= {~^tx_data, tx_data};
            r_cnt        <= '0;
            r_clk_oe     <= 1'b1;
            r_tx_ready   <= 1'b0;
            r_rx_inhibit <= 1'b1;
            r_state      <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (r_cnt == c_INH_LAST) begin
            r_cnt     <= '0;
            r_data_oe <= 1'b1;
            r_state   <= S_START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_START: begin
          // Releasing the clock with data held low is the request-to-send.
          r_clk_oe <= 1'b0;
          r_cnt    <= '0;
          r_state  <= S_RELEASE;
        end

        S_RELEASE: begin
          r_cnt   <= r_cnt + 1'b1;
          r_bit   <= '0;
          r_state <= S_BITS;
        end

        S_BITS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_clk_fall) begin
            if (r_bit == 4'd9) begin
              r_data_oe <= 1'b0;
              r_state   <= S_ACK;
            end else begin
              r_data_oe <= ~r_shift[r_bit];
            end
            r_bit <= r_bit + 1'b1;
          end
        end

        S_ACK: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_clk_fall && !r_data_s2) begin
            r_state <= S_WAIT_IDLE;
          end
        end

        S_WAIT_IDLE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_clk_s2 && r_data_s2) begin
            r_tx_done    <= 1'b1;
            r_tx_ready   <= 1'b1;
            r_rx_inhibit <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_clk_oe     <= 1'b0;
          r_data_oe    <= 1'b0;
          r_tx_ready   <= 1'b1;
          r_rx_inhibit <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase

      // Failure handling overrides whatever the state above decided, so a
      // timeout landing on the completion cycle can never also pulse done.
      if (w_fail) begin
        r_tx_done <= 1'b0;
        r_cnt     <= '0;
        r_bit     <= '0;
        if (w_retry) begin
          r_clk_oe  <= 1'b1;
          r_data_oe <= 1'b0;
          r_state   <= S_INHIBIT;
        end else begin
          r_tx_err     <= 1'b1;
          r_clk_oe     <= 1'b0;
          r_data_oe    <= 1'b0;
          r_tx_ready   <= 1'b1;
          r_rx_inhibit <= 1'b0;
          r_state      <= S_IDLE;
        end
      end
    end
  end

  assign tx_ready    = r_tx_ready;
  assign tx_done     = r_tx_done;
  assign tx_err      = r_tx_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign rx_inhibit  = r_rx_inhibit;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx with a keyboard model on an
//            open-drain bus, a cycle-level reference of the request phase
//            and directed transactions (ACK, NACK, timeout, reset, back-to-
//            back). Honours PS2_TX_RETRY_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 600;
  localparam int H   = 8;   // device clock half period in clk cycles
`ifdef PS2_TX_RETRY_EN
  localparam int RETRY = 1;
`else
  localparam int RETRY = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe, rx_inhibit;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  wire        bus_clk  = dev_clk  & ~ps2_clk_oe;
  wire        bus_data = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_i  (bus_clk),
    .ps2_data_i (bus_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .rx_inhibit (rx_inhibit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame as seen by the device: {stop, odd parity, data}.
  function automatic logic [9:0] exp_bits(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  // ---------------- reference model and per-cycle compare ----------------
  bit chk_en = 1'b0;
  bit m_busy = 1'b0;
  int m_n = 0;            // cycles since the byte was accepted
  int cyc = 0;
  int n_done = 0, n_err = 0;
  int t_release = 0, t_err = 0;
  int inh_run = 0, last_inh_len = 0, inh_runs = 0;
  logic prev_done = 1'b0, prev_err = 1'b0, prev_clk_oe = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_n    = 0;
    end else if (!m_busy && tx_valid) begin
      m_busy = 1'b1;
      m_n    = 1;
    end else if (m_busy) begin
      m_n++;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      if (tx_done) n_done++;
      if (tx_err) begin
        n_err++;
        t_err = cyc;
      end
      if (tx_done || tx_err) m_busy = 1'b0;
      chk("ready_vs_model", tx_ready, !m_busy);
      chk("rx_inhibit_vs_model", rx_inhibit, m_busy);
      chk("done_err_exclusive", tx_done & tx_err, 0);
      if (!m_busy)             chk("idle_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      else if (m_n <= INH)     chk("inhibit_phase", {ps2_clk_oe, ps2_data_oe}, 2'b10);
      else if (m_n == INH + 1) chk("start_phase", {ps2_clk_oe, ps2_data_oe}, 2'b11);
      else if (m_n == INH + 2) chk("release_phase", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      if (prev_done) chk("done_single_cycle", tx_done, 0);
      if (prev_err)  chk("err_single_cycle", tx_err, 0);
      if (ps2_clk_oe && !ps2_data_oe) begin
        inh_run++;
      end else if (inh_run > 0) begin
        last_inh_len = inh_run;
        inh_runs++;
        inh_run = 0;
      end
      if (prev_clk_oe && !ps2_clk_oe && ps2_data_oe) t_release = cyc;
    end
    prev_done   = tx_done;
    prev_err    = tx_err;
    prev_clk_oe = ps2_clk_oe;
  end

  // ---------------- keyboard model ----------------
  task automatic dev_frame(input bit ack, input int nfall, output logic [9:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (!(bus_clk === 1'b1 && bus_data === 1'b0) && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("dev_request_seen", (w < 400), 1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < nfall; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      bits[i] = bus_data;
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    if (nfall == 10) begin
      if (ack) dev_data = 1'b0;
      repeat (2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (2) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic send_start(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_event(input int base, input int budget, input string name);
    int w;
    w = 0;
    while (!(tx_done || tx_err || ((n_done + n_err) > base)) && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_completion_seen"}, (w < budget), 1);
  endtask

  task automatic ack_frame(input logic [7:0] b, input logic [9:0] lit, input string name);
    logic [9:0] bits;
    int bd, be;
    bd = n_done;
    be = n_err;
    send_start(b);
    dev_frame(1'b1, 10, bits);
    wait_event(bd + be, 200, name);
    repeat (3) @(negedge clk);
    chk({name, "_bits_literal"}, bits, lit);
    chk({name, "_bits_model"}, bits, exp_bits(b));
    chk({name, "_done_pulses"}, n_done - bd, 1);
    chk({name, "_err_pulses"}, n_err - be, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    logic [9:0] bits, bits2;
    int bd, be, ir;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_tx_done", tx_done, 0);
    chk("reset_tx_err", tx_err, 0);
    chk("reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("reset_rx_inhibit", rx_inhibit, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // ACKed frames; 0x00 and 0x01 exercise both parity values
    ack_frame(8'hED, 10'h3ED, "ed");
    chk("ed_inhibit_len", last_inh_len, INH);
    ack_frame(8'h00, 10'h300, "x00");
    ack_frame(8'h01, 10'h201, "x01");

    // NACK on 0xFF
    bd = n_done; be = n_err; ir = inh_runs;
    send_start(8'hFF);
    dev_frame(1'b0, 10, bits);
`ifdef PS2_TX_RETRY_EN
    chk("nack_first_no_err", n_err - be, 0);
    dev_frame(1'b0, 10, bits);
    chk("nack_retry_inhibit_len", last_inh_len, INH);
`endif
    wait_event(bd + be, 100, "nack");
    repeat (3) @(negedge clk);
    chk("nack_err_pulses", n_err - be, 1);
    chk("nack_done_pulses", n_done - bd, 0);
    chk("nack_inhibit_runs", inh_runs - ir, 1 + RETRY);
    chk("nack_bits_model", bits, exp_bits(8'hFF));
    chk("nack_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // silent device: timeout
    bd = n_done; be = n_err; ir = inh_runs;
    send_start(8'h55);
    wait_event(bd + be, 3 * TMO + 200, "tmo");
    repeat (2) @(negedge clk);
    chk("tmo_err_pulses", n_err - be, 1);
    chk("tmo_done_pulses", n_done - bd, 0);
    chk("tmo_latency", t_err - t_release, TMO);
    chk("tmo_inhibit_runs", inh_runs - ir, 1 + RETRY);
    chk("tmo_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // reset during k=4 of the bit phase (bit 4 of 0x2F is 0: line driven)
    bd = n_done; be = n_err;
    send_start(8'h2F);
    dev_frame(1'b1, 4, bits);
    dev_clk = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_k4_data_oe", ps2_data_oe, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_tx_ready", tx_ready, 1);
    chk("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("rst_mid_pulses", {tx_done, tx_err}, 2'b00);
    chk("rst_mid_rx_inhibit", rx_inhibit, 0);
    rst_n   = 1'b1;
    dev_clk = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_mid_no_done", n_done - bd, 0);
    chk("rst_mid_no_err", n_err - be, 0);

    // tx_valid held high across the done pulse: 0xF3 then 0x20
    bd = n_done; be = n_err;
    tx_data  = 8'hF3;
    tx_valid = 1'b1;
    dev_frame(1'b1, 10, bits);
    wait_event(bd + be, 200, "b2b_first");
    chk("b2b_first_done_ready", tx_ready, 1);
    tx_data = 8'h20;
    @(negedge clk);
    chk("b2b_second_accepted", tx_ready, 0);
    tx_valid = 1'b0;
    dev_frame(1'b1, 10, bits2);
    wait_event(bd + be + 1, 200, "b2b_second");
    repeat (3) @(negedge clk);
    chk("b2b_first_bits", bits, 10'h3F3);
    chk("b2b_second_bits", bits2, 10'h220);
    chk("b2b_second_model", bits2, exp_bits(8'h20));
    chk("b2b_done_pulses", n_done - bd, 2);
    chk("b2b_err_pulses", n_err - be, 0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
